e_mdu_ctrl: RTL



---
 rtl/e_mdu_ctrl_pkg.sv | 41 ++++
 rtl/e_mdu_arith.sv | 84 ++++++++
 rtl/e_mdu_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_ctrl_pkg
// Description : Shared definitions for the execute-stage multiply/divide
//               controller. Holds the MDU_* operation codes, the default
//               latency constants, the controller state encoding and small
//               op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package e_mdu_ctrl_pkg;

    // 3-bit MDU operation codes driven by the E stage
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Default multi-cycle latencies
    localparam int MDU_MULT_CYCLES_DFLT = 5;
    localparam int MDU_DIV_CYCLES_DFLT  = 10;

    // Controller state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // True for the ops that occupy the unit for several cycles
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_arith
// Description : Combinational multiply/divide datapath. Produces the 64-bit
//               {HI,LO} result for the latched op and operands, plus a write
//               enable that is low for a divide by zero (HI/LO stay put).
// Ports       : i_op     - latched MDU op code
//               i_a      - latched operand A (rs)
//               i_b      - latched operand B (rt)
//               o_result - {HI,LO} result
//               o_wr_en  - commit the result at completion
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_wr_en
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_signed_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic        [31:0] w_a_mag;
    logic        [31:0] w_b_mag;
    logic        [31:0] w_dvd;
    logic        [31:0] w_dvs;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_quot;
    logic        [31:0] w_rem;

    // Sign-extend to 64 bits so the product is exact
    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide is done on magnitudes with one shared unsigned divider.
    // The magnitude of 0x80000000 is 0x80000000 as an unsigned value, so the
    // overflow case 0x80000000 / -1 falls out as quotient 0x80000000, rem 0
    // with no special-casing.
    assign w_signed_div = (i_op == MDU_DIV);
    assign w_a_neg      = w_signed_div & i_a[31];
    assign w_b_neg      = w_signed_div & i_b[31];
    assign w_a_mag      = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_b_mag      = w_b_neg ? (~i_b + 32'd1) : i_b;
    assign w_dvd        = w_a_mag;
    // Keep the divider away from zero; the result is discarded in that case
    assign w_dvs        = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_dvd / w_dvs;
    assign w_r_mag      = w_dvd % w_dvs;
    // Quotient truncates toward zero; remainder takes the dividend's sign
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        o_result = 64'd0;
        o_wr_en  = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_result = w_prod_s;
                o_wr_en  = 1'b1;
            end
            MDU_MULTU: begin
                o_result = w_prod_u;
                o_wr_en  = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                o_result = {w_rem, w_quot};
                o_wr_en  = (i_b != 32'd0);
            end
            default: begin
                o_result = 64'd0;
                o_wr_en  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_ctrl
// Description : Execute-stage multiply/divide controller. Accepts
//               MULT/MULTU/DIV/DIVU/MTHI/MTLO, latches operands, models the
//               multi-cycle latency with a busy countdown and owns HI/LO.
// Ports       : clk      - clock, rising edge
//               reset    - synchronous active-high reset
//               start    - E-stage instruction is an MDU op
//               mdu_op   - MDU op code (MDU_* in e_mdu_ctrl_pkg)
//               rs, rt   - operands (rs is also the MTHI/MTLO source)
//               req      - exception/interrupt flush, suppresses start
//               busy     - multiply/divide in flight
//               hi, lo   - architectural HI/LO registers
//               div_zero - sticky divide-by-zero flag (MDU_DIVZERO_FLAG_EN)
// Config      : MDU_DIVZERO_FLAG_EN - adds the div_zero port and its logic
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    output logic        div_zero
`endif
);

    // Counter is 4 bits unless a latency needs more
    localparam int c_CNT_MAX = ((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) - 1;
    localparam int c_CNT_W   = (c_CNT_MAX > 15) ? $clog2(c_CNT_MAX + 1) : 4;

    mdu_state_e           r_state;
    mdu_state_e           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic                 w_accept;
    logic                 w_start_muldiv;
    logic                 w_complete;
    logic [63:0]          w_arith_res;
    logic                 w_arith_wr;

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    e_mdu_arith u_arith (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_arith_res),
        .o_wr_en  (w_arith_wr)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_start_muldiv = 1'b0;
        w_complete     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept       = start & ~req;
                w_start_muldiv = w_accept & is_muldiv(mdu_op);
                if (w_start_muldiv) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // start is ignored here; the hazard unit never issues one
                if (r_cnt == '0) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latches, countdown and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MDU_MULT;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_start_muldiv) begin
                r_op  <= mdu_op;
                r_a   <= rs;
                r_b   <= rt;
                r_cnt <= is_div(mdu_op) ? c_CNT_W'(DIV_CYCLES - 1)
                                        : c_CNT_W'(MULT_CYCLES - 1);
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            // Completion and an accept never share an edge (accept needs IDLE)
            if (w_complete && w_arith_wr) begin
                r_hi <= w_arith_res[63:32];
                r_lo <= w_arith_res[31:0];
            end else if (w_accept && (mdu_op == MDU_MTHI)) begin
                r_hi <= rs;
            end else if (w_accept && (mdu_op == MDU_MTLO)) begin
                r_lo <= rs;
            end
        end
    end

`ifdef MDU_DIVZERO_FLAG_EN
    logic r_div_zero;

    // Set when a divide by zero completes; cleared by the next accepted
    // divide with a non-zero divisor
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_zero <= 1'b0;
        end else if (w_complete && is_div(r_op) && (r_b == 32'd0)) begin
            r_div_zero <= 1'b1;
        end else if (w_start_muldiv && is_div(mdu_op) && (rt != 32'd0)) begin
            r_div_zero <= 1'b0;
        end
    end

    assign div_zero = r_div_zero;
`endif

    assign busy = (r_state == ST_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
